prio_arbiter16: RTL and testbench

Sixteen-way request arbiter that shares one downstream resource between up to 16 requesters. Built around a masked priority-encode stage. Selects fixed-priority (highest index wins) or round-robin per cycle, then holds the grant until the owner releases or a hold limit expires. Sits between the request sources and the shared datapath it sequences.

---
 rtl/arb_pkg.sv | 12 +
 rtl/masked_prio_enc16.sv | 45 ++++
 rtl/prio_arbiter16.sv | 131 +++++++++++++
 tb/tb_prio_arbiter16.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 16-way priority arbiter.
package arb_pkg;

   localparam int N     = 16;
   localparam int IDX_W = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/masked_prio_enc16.sv
// Combinational masked priority encoder: highest index wins in fixed mode,
// first set bit at or above start (wrapping) wins in round-robin mode.
module masked_prio_enc16
   import arb_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] start,
   input  logic             rr,
   output logic             found,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   logic [N-1:0]     cand;
   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rot;
   logic [IDX_W-1:0] off;

   // Rotate so start lands on bit 0, take the lowest set bit, then un-rotate.
   always_comb begin
      cand  = req & ~mask;
      dbl   = {cand, cand} >> start;
      rot   = dbl[N-1:0];
      found = |cand;
      off   = {IDX_W{1'b0}};
      idx   = {IDX_W{1'b0}};
      if (rr) begin
         for (int i = N - 1; i >= 0; i--) begin
            off = rot[i] ? IDX_W'(i) : off;
         end
         idx = start + off;
      end else begin
         for (int i = 0; i < N; i++) begin
            idx = cand[i] ? IDX_W'(i) : idx;
         end
      end
      if (found) begin
         onehot = {{(N-1){1'b0}}, 1'b1} << idx;
      end else begin
         onehot = {N{1'b0}};
      end
   end

endmodule

// File: rtl/prio_arbiter16.sv
// Sixteen-way arbiter: fixed or round-robin selection, grant held until the
// owner releases or the hold limit revokes it.
module prio_arbiter16
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             rr_en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic [IDX_W-1:0] rr_ptr, next_rr_ptr;
   logic [N-1:0]     excl_mask, next_excl_mask;
   logic [N-1:0]     next_gnt;
   logic [IDX_W-1:0] next_gnt_idx;
   logic             next_gnt_valid;
   logic             next_timeout;

   logic [N-1:0]     enc_mask;
   logic             enc_found;
   logic [IDX_W-1:0] enc_idx;
   logic [N-1:0]     enc_onehot;

   // Drop the exclusion when the excluded requester is the only one asking.
   always_comb begin
      if (|(req & ~excl_mask)) begin
         enc_mask = excl_mask;
      end else begin
         enc_mask = {N{1'b0}};
      end
   end

   masked_prio_enc16 u_enc (
      .req    (req),
      .mask   (enc_mask),
      .start  (rr_ptr),
      .rr     (rr_en),
      .found  (enc_found),
      .idx    (enc_idx),
      .onehot (enc_onehot)
   );

   // Next-state and next-output logic for the IDLE/GRANT machine.
   always_comb begin
      next_state     = state;
      next_cnt       = cnt;
      next_rr_ptr    = rr_ptr;
      next_excl_mask = excl_mask;
      next_gnt       = gnt;
      next_gnt_idx   = gnt_idx;
      next_gnt_valid = gnt_valid;
      next_timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (enc_found) begin
               next_state     = GRANT;
               next_gnt       = enc_onehot;
               next_gnt_idx   = enc_idx;
               next_gnt_valid = 1'b1;
               next_cnt       = {CNT_W{1'b0}};
               next_rr_ptr    = enc_idx + 4'd1;
               next_excl_mask = {N{1'b0}};
            end else begin
               next_gnt       = {N{1'b0}};
               next_gnt_idx   = {IDX_W{1'b0}};
               next_gnt_valid = 1'b0;
            end
         end
         GRANT: begin
            next_cnt = cnt + CNT_W'(1);
            if (!req[gnt_idx]) begin
               next_state     = IDLE;
               next_gnt       = {N{1'b0}};
               next_gnt_idx   = {IDX_W{1'b0}};
               next_gnt_valid = 1'b0;
            end else if ((MAX_HOLD != 0) && (cnt == HOLD_LAST)) begin
               // Revoke and keep this owner out of the next contested arbitration.
               next_state     = IDLE;
               next_timeout   = 1'b1;
               next_excl_mask = gnt;
               next_gnt       = {N{1'b0}};
               next_gnt_idx   = {IDX_W{1'b0}};
               next_gnt_valid = 1'b0;
            end else begin
               next_state = GRANT;
            end
         end
         default: begin
            next_state     = IDLE;
            next_gnt       = {N{1'b0}};
            next_gnt_idx   = {IDX_W{1'b0}};
            next_gnt_valid = 1'b0;
         end
      endcase
   end

   // State, counter, pointer, mask and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= {CNT_W{1'b0}};
         rr_ptr    <= {IDX_W{1'b0}};
         excl_mask <= {N{1'b0}};
         gnt       <= {N{1'b0}};
         gnt_idx   <= {IDX_W{1'b0}};
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= next_cnt;
         rr_ptr    <= next_rr_ptr;
         excl_mask <= next_excl_mask;
         gnt       <= next_gnt;
         gnt_idx   <= next_gnt_idx;
         gnt_valid <= next_gnt_valid;
         timeout   <= next_timeout;
      end
   end

endmodule

// File: tb/tb_prio_arbiter16.sv
// Self-checking bench for prio_arbiter16: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_prio_arbiter16;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = 16'h0000;
   logic        rr_en = 1'b0;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   int tests_run = 0;
   int fails = 0;

   // Model state: owner index (-1 = none), granted cycles so far, rr pointer,
   // excluded requester (-1 = none), timeout flag visible this cycle.
   int m_owner = -1;
   int m_hold  = 0;
   int m_ptr   = 0;
   int m_excl  = -1;
   bit m_to    = 1'b0;

   logic [21:0] obs;
   logic [21:0] exp_v;

   prio_arbiter16 #(.MAX_HOLD(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .rr_en     (rr_en),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input logic [15:0] r, input logic rr, input logic rs);
      logic [15:0] cm;
      int w;
      if (rs) begin
         m_owner = -1; m_hold = 0; m_ptr = 0; m_excl = -1; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         cm = r;
         if (m_excl >= 0) cm[m_excl] = 1'b0;
         if (cm == 16'h0000 && m_excl >= 0 && r[m_excl]) cm[m_excl] = 1'b1;
         w = -1;
         if (rr) begin
            for (int k = 15; k >= 0; k--)
               if (cm[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
         end else begin
            for (int i = 0; i < 16; i++)
               if (cm[i]) w = i;
         end
         if (w >= 0) begin
            m_owner = w; m_hold = 1; m_ptr = (w + 1) % 16; m_excl = -1;
         end
      end else begin
         m_to = 1'b0;
         if (!r[m_owner]) begin
            m_owner = -1;
         end else if (HOLD != 0 && m_hold == HOLD) begin
            m_to = 1'b1; m_excl = m_owner; m_owner = -1;
         end else begin
            m_hold++;
         end
      end
   endtask

   function automatic logic [21:0] model_vec();
      logic [15:0] g;
      logic [3:0]  ix;
      g  = 16'h0000;
      ix = 4'd0;
      if (m_owner >= 0) begin
         g[m_owner] = 1'b1;
         ix = 4'(m_owner);
      end
      return {g, ix, (m_owner >= 0), m_to};
   endfunction

   task automatic tick(input logic [15:0] r, input logic rr, input logic rs);
      req = r; rr_en = rr; rst = rs;
      @(posedge clk);
      model_edge(r, rr, rs);
      #1;
      obs   = {gnt, gnt_idx, gnt_valid, timeout};
      exp_v = model_vec();
   endtask

   task automatic test_reset();
      tick(16'hFFFF, 1'b0, 1'b1);
      tick(16'hFFFF, 1'b0, 1'b1);
      tests_run++;
      if (obs !== 22'h0) begin
         fails++;
         $display("FAIL reset_state: got %h want %h", obs, 22'h0);
      end
   endtask

   task automatic test_fixed_priority();
      tick(16'h0000, 1'b0, 1'b1);
      tick(16'h8001, 1'b0, 1'b0);
      tests_run++;
      if (gnt !== 16'h8000 || gnt_idx !== 4'd15 || gnt_valid !== 1'b1) begin
         fails++;
         $display("FAIL fixed_high: got gnt=%h idx=%0d want gnt=8000 idx=15", gnt, gnt_idx);
      end
      tick(16'h0001, 1'b0, 1'b0);
      tests_run++;
      if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin
         fails++;
         $display("FAIL fixed_dead: got gnt=%h valid=%b want 0", gnt, gnt_valid);
      end
      tick(16'h0001, 1'b0, 1'b0);
      tests_run++;
      if (gnt !== 16'h0001 || gnt_idx !== 4'd0 || gnt_valid !== 1'b1) begin
         fails++;
         $display("FAIL fixed_low: got gnt=%h idx=%0d want gnt=0001 idx=0", gnt, gnt_idx);
      end
      tick(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_round_robin();
      int order [4] = '{0, 4, 8, 0};
      logic [15:0] r;
      tick(16'h0000, 1'b1, 1'b1);
      for (int g = 0; g < 4; g++) begin
         tick(16'h0111, 1'b1, 1'b0);
         tests_run++;
         if (gnt_valid !== 1'b1 || gnt_idx !== 4'(order[g]) || obs !== exp_v) begin
            fails++;
            $display("FAIL rr_order[%0d]: got idx=%0d valid=%b want idx=%0d", g, gnt_idx, gnt_valid, order[g]);
         end
         r = 16'h0111;
         r[order[g]] = 1'b0;
         tick(r, 1'b1, 1'b0);
         tests_run++;
         if (gnt_valid !== 1'b0 || gnt !== 16'h0000) begin
            fails++;
            $display("FAIL rr_dead[%0d]: got gnt=%h valid=%b want 0", g, gnt, gnt_valid);
         end
      end
   endtask

   task automatic test_timeout();
      tick(16'h0000, 1'b0, 1'b1);
      for (int c = 1; c <= 11; c++) begin
         tick(16'h0003, 1'b0, 1'b0);
         tests_run++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL timeout_model[%0d]: got %h want %h", c, obs, exp_v);
         end
         if (c <= 4) begin
            tests_run++;
            if (gnt_idx !== 4'd1 || gnt_valid !== 1'b1) begin
               fails++;
               $display("FAIL timeout_hold[%0d]: got idx=%0d valid=%b want idx=1 valid=1", c, gnt_idx, gnt_valid);
            end
         end else if (c == 5) begin
            tests_run++;
            if (timeout !== 1'b1 || gnt_valid !== 1'b0) begin
               fails++;
               $display("FAIL timeout_pulse: got timeout=%b valid=%b want 1/0", timeout, gnt_valid);
            end
         end else if (c == 6) begin
            tests_run++;
            if (gnt_idx !== 4'd0 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
               fails++;
               $display("FAIL timeout_excl: got idx=%0d valid=%b to=%b want idx=0 valid=1 to=0", gnt_idx, gnt_valid, timeout);
            end
         end else if (c == 11) begin
            tests_run++;
            if (gnt_idx !== 4'd1 || gnt_valid !== 1'b1) begin
               fails++;
               $display("FAIL timeout_back: got idx=%0d valid=%b want idx=1", gnt_idx, gnt_valid);
            end
         end
      end
      tick(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_lone_timeout();
      tick(16'h0000, 1'b0, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         tick(16'h0020, 1'b0, 1'b0);
         tests_run++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL lone_model[%0d]: got %h want %h", c, obs, exp_v);
         end
      end
      tests_run++;
      if (gnt_idx !== 4'd5 || gnt_valid !== 1'b1) begin
         fails++;
         $display("FAIL lone_regrant: got idx=%0d valid=%b want idx=5", gnt_idx, gnt_valid);
      end
      tick(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      tick(16'h0000, 1'b1, 1'b1);
      tick(16'h8000, 1'b1, 1'b0);
      tests_run++;
      if (gnt_idx !== 4'd15 || gnt_valid !== 1'b1) begin
         fails++;
         $display("FAIL wrap_15: got idx=%0d valid=%b want idx=15", gnt_idx, gnt_valid);
      end
      tick(16'h0000, 1'b1, 1'b0);
      tick(16'h8002, 1'b1, 1'b0);
      tests_run++;
      if (gnt_idx !== 4'd1 || gnt_valid !== 1'b1) begin
         fails++;
         $display("FAIL wrap_next: got idx=%0d valid=%b want idx=1", gnt_idx, gnt_valid);
      end
      tick(16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_grant();
      tick(16'h0000, 1'b0, 1'b1);
      tick(16'h0080, 1'b0, 1'b0);
      tests_run++;
      if (gnt_idx !== 4'd7 || gnt_valid !== 1'b1) begin
         fails++;
         $display("FAIL mid_setup: got idx=%0d want 7", gnt_idx);
      end
      tick(16'h0080, 1'b0, 1'b1);
      tests_run++;
      if (obs !== 22'h0) begin
         fails++;
         $display("FAIL mid_reset: got %h want 0", obs);
      end
      tick(16'hFFFF, 1'b1, 1'b0);
      tests_run++;
      if (gnt_idx !== 4'd0 || gnt !== 16'h0001 || gnt_valid !== 1'b1) begin
         fails++;
         $display("FAIL mid_rrptr: got gnt=%h idx=%0d want gnt=0001 idx=0", gnt, gnt_idx);
      end
      tick(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [15:0] r;
      logic        rr;
      logic        rs;
      r  = 16'h0000;
      rr = 1'b0;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(3) == 0) r = 16'($urandom) & 16'($urandom);
         if ($urandom_range(7) == 0) rr = ~rr;
         rs = ($urandom_range(63) == 0);
         tick(r, rr, rs);
         tests_run++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL random[%0d]: got %h want %h (req=%h rr=%b)", n, obs, exp_v, r, rr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_timeout();
      test_lone_timeout();
      test_wrap();
      test_reset_mid_grant();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
